// File: rtl/noc_pkg.sv
// Shared constants and types for the PE-to-NoC network interface.
package noc_pkg;
  localparam int DEST_MSB  = 31;
  localparam int DEST_LSB  = 24;
  localparam int PAYLOAD_W = 24;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;
endpackage

// File: rtl/noc_skid_buffer.sv
// Two-entry skid buffer; ready is registered so no valid->ready comb path exists.
module noc_skid_buffer
  import noc_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [Width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);
  skid_state_t      state, state_nxt;
  logic [Width-1:0] head, tail;
  logic             ready_q;
  logic             push, pop;

  assign push      = in_valid & ready_q;
  assign pop       = out_valid & out_ready;
  assign in_ready  = ready_q;
  assign out_valid = (state != EMPTY);
  assign out_data  = head;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (push) state_nxt = ONE;
      ONE:     if (push && !pop) state_nxt = FULL;
               else if (!push && pop) state_nxt = EMPTY;
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
      head    <= '0;
      tail    <= '0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != FULL);
      case (state)
        EMPTY: if (push) head <= in_data;
        ONE: begin
          // push+pop replaces the head; push alone parks the word behind it
          if (push && pop) head <= in_data;
          else if (push)   tail <= in_data;
        end
        FULL:  if (pop) head <= tail;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/pe_noc_interface.sv
// PE <-> leaf-switch network interface: Tx flit packing, Rx address filter, drop counter.
// Define PE_NOC_INTERFACE_STATS_EN to add saturating Tx/Rx transfer counters.
module pe_noc_interface
  import noc_pkg::*;
#(
  parameter int         DataWidth    = 32,
  parameter logic [7:0] MyAddr       = 8'd0,
  parameter int         DropCntWidth = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [PAYLOAD_W-1:0]    i_pe_data,
  input  logic [7:0]              i_pe_dest,
  input  logic                    i_pe_valid,
  output logic                    o_pe_ready,
  output logic [DataWidth-1:0]    o_data,
  output logic                    o_data_valid,
  input  logic                    i_data_ready,
  input  logic [DataWidth-1:0]    i_data,
  input  logic                    i_data_valid,
  output logic                    o_data_ready,
  output logic [PAYLOAD_W-1:0]    o_pe_data,
  output logic                    o_pe_valid,
  input  logic                    i_pe_ready,
`ifdef PE_NOC_INTERFACE_STATS_EN
  output logic [15:0]             o_tx_cnt,
  output logic [15:0]             o_rx_cnt,
`endif
  output logic [DropCntWidth-1:0] o_drop_cnt
);
  logic match, rx_accept;

  noc_skid_buffer #(.Width(DataWidth)) u_tx_skid (
    .clk      (i_clk),
    .reset    (i_reset),
    .in_data  ({i_pe_dest, i_pe_data}),
    .in_valid (i_pe_valid),
    .in_ready (o_pe_ready),
    .out_data (o_data),
    .out_valid(o_data_valid),
    .out_ready(i_data_ready)
  );

  // Misrouted flits still wait on the Rx skid ready so flit order is kept.
  assign match     = (i_data[DEST_MSB:DEST_LSB] == MyAddr);
  assign rx_accept = i_data_valid & o_data_ready;

  noc_skid_buffer #(.Width(PAYLOAD_W)) u_rx_skid (
    .clk      (i_clk),
    .reset    (i_reset),
    .in_data  (i_data[PAYLOAD_W-1:0]),
    .in_valid (i_data_valid & match),
    .in_ready (o_data_ready),
    .out_data (o_pe_data),
    .out_valid(o_pe_valid),
    .out_ready(i_pe_ready)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset)
      o_drop_cnt <= '0;
    else if (rx_accept && !match && (o_drop_cnt != {DropCntWidth{1'b1}}))
      o_drop_cnt <= o_drop_cnt + 1'b1;
  end

`ifdef PE_NOC_INTERFACE_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_tx_cnt <= '0;
      o_rx_cnt <= '0;
    end else begin
      if (o_data_valid && i_data_ready && (o_tx_cnt != 16'hFFFF)) o_tx_cnt <= o_tx_cnt + 16'd1;
      if (o_pe_valid && i_pe_ready && (o_rx_cnt != 16'hFFFF))     o_rx_cnt <= o_rx_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: doc/pe_noc_interface.md
Name: pe_noc_interface

Overview:
- Network interface between one processing element (PE) and the bottom port of its leaf switch in the 16-PE hierarchical NoC.
- Tx path: packs a PE payload and a destination address into a 32-bit flit, dest in flit[31:24]. Flits are presented to the switch input.
- Rx path: accepts flits from the switch output and checks flit[31:24] against the local address. Matching flits deliver flit[23:0] to the PE; misrouted flits are dropped and counted.
- Both paths are registered through 2-entry skid buffers, so no combinational valid/ready path crosses the interface.

Parameters:
- DataWidth, 32, flit width; must be 32.
- MyAddr, 0, this PE's 8-bit network address.
- DropCntWidth, 8, width of the saturating misroute counter.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_pe_data  in  24  Tx payload from PE
- i_pe_dest  in  8  Tx destination address
- i_pe_valid  in  1  Tx payload valid
- o_pe_ready  out  1  Tx payload accepted
- o_data  out  32  flit to switch
- o_data_valid  out  1  flit valid
- i_data_ready  in  1  switch accepts flit
- i_data  in  32  flit from switch
- i_data_valid  in  1  incoming flit valid
- o_data_ready  out  1  interface accepts flit
- o_pe_data  out  24  Rx payload to PE
- o_pe_valid  out  1  Rx payload valid
- i_pe_ready  in  1  PE accepts payload
- o_drop_cnt  out  DropCntWidth  misrouted-flit count

Behaviour:
- Handshakes: all are valid/ready. A transfer occurs on a rising edge of i_clk with valid&ready high.
- Valid stability: valid, once high, holds with stable data until the transfer.
- Skid buffer (used on both paths): 2 entries, states EMPTY, ONE, FULL.
  - ready = (state != FULL), driven from a register.
  - valid = (state != EMPTY).
  - Output data is always the oldest entry.
- Skid transitions:
  - EMPTY + push -> ONE.
  - ONE + push only -> FULL.
  - ONE + pop only -> EMPTY.
  - ONE + push + pop -> ONE, new word becomes head.
  - FULL + pop -> ONE.
  - Push while FULL is impossible because ready is low.
- Tx path:
  - Push word = {i_pe_dest, i_pe_data}, pushed when i_pe_valid & o_pe_ready.
  - Latency: 1 cycle from accept to o_data_valid when empty.
  - Full throughput: 1 flit/cycle under continuous ready.
- Tx with dest == MyAddr is forwarded unchanged; the switch handles routing.
- Rx path:
  - Flit accepted when i_data_valid & o_data_ready.
  - If i_data[31:24] == MyAddr, push i_data[23:0] into the Rx skid; latency 1 cycle.
  - Otherwise the flit is consumed and discarded, and o_drop_cnt increments.
- Rx backpressure: o_data_ready = Rx skid not FULL. Misrouted flits are still subject to this ready, so ordering is preserved.
- o_drop_cnt saturates at all-ones and does not wrap.
- Reset (synchronous, any time including mid-transfer):
  - Both skids go to EMPTY; o_data_valid = 0, o_pe_valid = 0.
  - o_pe_ready = 1 and o_data_ready = 1 from the first cycle after reset deasserts.
  - o_drop_cnt = 0. In-flight words are lost.
- Reset value of data outputs: o_data = 0, o_pe_data = 0.
- The Tx and Rx paths are fully independent; simultaneous activity on both is legal every cycle.

Optional Feature:
- Macro: PE_NOC_INTERFACE_STATS_EN.
- When defined:
  - Extra outputs o_tx_cnt[15:0] and o_rx_cnt[15:0].
  - o_tx_cnt counts flits accepted by the switch.
  - o_rx_cnt counts payloads accepted by the PE.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package noc_pkg:
  - Constants DEST_MSB = 31, DEST_LSB = 24, PAYLOAD_W = 24.
  - Typedef for the skid state enum (EMPTY, ONE, FULL).
- Sub-module noc_skid_buffer (parameterised width), instantiated twice: Tx at width 32, Rx at width 24.

Test Plan:
- Tx single: MyAddr=5, pe_dest=8'h0A, pe_data=24'h123456, i_data_ready=1 -> next cycle o_data=32'h0A123456, o_data_valid=1, then 0.
- Tx backpressure: i_data_ready=0, push 3 payloads -> o_pe_ready drops after 2 accepted. Release ready -> 2 flits emerge in order with no loss or duplication.
- Rx match/mismatch: MyAddr=5, send 32'h05AABBCC then 32'h07000001 -> o_pe_data=24'hAABBCC once; o_drop_cnt=1.
- Drop saturation: DropCntWidth=8, send 300 misrouted flits -> o_drop_cnt=8'hFF, with no Rx payload emitted.
- Streaming: 100 random back-to-back flits each direction with random ready toggling -> scoreboard shows in-order delivery. Throughput is 1/cycle while ready stays high.
- Reset mid-op: both skids FULL, assert i_reset one cycle -> both valids 0 and o_drop_cnt=0 next cycle, both readies 1.
